// File: rtl/pc_update_unit_if.sv
// Bundle between branch resolution / decode and the PC stage, plus the fetch-side outputs.
// slave is the PC unit; master is whoever drives branch decisions and consumes the fetch address.
interface pc_update_unit_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            br_valid;
  logic            br_taken;
  logic [5:0]      opcode;
  logic [PC_W-1:0] br_pc;
  logic [25:0]     imm26;
  logic [15:0]     imm16;
  logic [PC_W-1:0] rs_data;
  logic            halt_req;

  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            squash;
  logic            link_we;
  logic [PC_W-1:0] link_data;
  logic            align_err;
  logic            halted;

  modport slave (
    input  stall, br_valid, br_taken, opcode, br_pc, imm26, imm16, rs_data, halt_req,
    output pc, pc_valid, squash, link_we, link_data, align_err, halted
  );

  modport master (
    output stall, br_valid, br_taken, opcode, br_pc, imm26, imm16, rs_data, halt_req,
    input  pc, pc_valid, squash, link_we, link_data, align_err, halted
  );
endinterface

// File: rtl/pc_update_unit.sv
// PC stage: picks PC+4, branch target or register target; new pc 1 clock after the branch input.
// stall freezes all state (pulses drop); HALTED ignores everything but rst_n.
module pc_update_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_update_unit_if.slave  pif
);

  localparam logic [5:0] OP_BLTZ = 6'b000111;
  localparam logic [5:0] OP_BZ   = 6'b001000;
  localparam logic [5:0] OP_BNZ  = 6'b001001;
  localparam logic [5:0] OP_BR   = 6'b001010;
  localparam logic [5:0] OP_B    = 6'b001011;
  localparam logic [5:0] OP_BL   = 6'b001100;
  localparam logic [5:0] OP_BCY  = 6'b001101;
  localparam logic [5:0] OP_BNCY = 6'b001110;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REDIR  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic            pc_valid_q, pc_valid_nxt;
  logic            squash_q, squash_nxt;
  logic            link_we_q, link_we_nxt;
  logic [PC_W-1:0] link_data_q, link_data_nxt;
  logic            align_err_q, align_err_nxt;
  logic            halted_q, halted_nxt;

  logic            is_rel26, is_rel16, is_reg, is_br;
  logic [PC_W-1:0] tgt_raw, tgt;
  logic [PC_W-1:0] off26, off16;
  logic [PC_W-1:0] pc_inc;
  logic            redirect;

  assign off26  = {{(PC_W-28){pif.imm26[25]}}, pif.imm26, 2'b00};
  assign off16  = {{(PC_W-18){pif.imm16[15]}}, pif.imm16, 2'b00};
  assign pc_inc = pc_q + PC_W'(4);

  always_comb begin
    is_rel26 = (pif.opcode == OP_B)    || (pif.opcode == OP_BL) ||
               (pif.opcode == OP_BCY)  || (pif.opcode == OP_BNCY);
    is_rel16 = (pif.opcode == OP_BLTZ) || (pif.opcode == OP_BZ) ||
               (pif.opcode == OP_BNZ);
    is_reg   = (pif.opcode == OP_BR);
    is_br    = is_rel26 || is_rel16 || is_reg;

    tgt_raw = pif.rs_data;
    if (is_rel26)
      tgt_raw = pif.br_pc + off26;
    else if (is_rel16)
      tgt_raw = pif.br_pc + off16;
    tgt = {tgt_raw[PC_W-1:2], 2'b00};
  end

  // Unknown opcodes with br_taken behave as not taken; REDIR/HALTED never redirect.
  assign redirect = pif.br_valid && pif.br_taken && is_br && !pif.stall && (state == RUN);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    pc_valid_nxt  = pc_valid_q;
    squash_nxt    = squash_q;
    link_we_nxt   = 1'b0;
    link_data_nxt = link_data_q;
    align_err_nxt = 1'b0;
    halted_nxt    = halted_q;

    case (state)
      RUN: begin
        if (pif.stall) begin
          squash_nxt = 1'b0;
        end else if (redirect) begin
          pc_nxt     = tgt;
          state_nxt  = REDIR;
          squash_nxt = 1'b1;
          if (pif.opcode == OP_BL) begin
            link_we_nxt   = 1'b1;
            link_data_nxt = pif.br_pc + PC_W'(4);
          end
          if (is_reg && (pif.rs_data[1:0] != 2'b00))
            align_err_nxt = 1'b1;
        end else if (pif.halt_req) begin
          state_nxt    = HALTED;
          pc_valid_nxt = 1'b0;
          halted_nxt   = 1'b1;
        end else begin
          pc_nxt = pc_inc;
        end
      end

      // The branch slot here belongs to the squashed instruction, so inputs are ignored.
      REDIR: begin
        if (!pif.stall) begin
          pc_nxt     = pc_inc;
          squash_nxt = 1'b0;
          state_nxt  = RUN;
        end
      end

      HALTED: begin
        state_nxt = HALTED;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b1;
      squash_q    <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      align_err_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      pc_valid_q  <= pc_valid_nxt;
      squash_q    <= squash_nxt;
      link_we_q   <= link_we_nxt;
      link_data_q <= link_data_nxt;
      align_err_q <= align_err_nxt;
      halted_q    <= halted_nxt;
    end
  end

  assign pif.pc        = pc_q;
  assign pif.pc_valid  = pc_valid_q;
  assign pif.squash    = squash_q;
  assign pif.link_we   = link_we_q;
  assign pif.link_data = link_data_q;
  assign pif.align_err = align_err_q;
  assign pif.halted    = halted_q;

endmodule
